// File: rtl/iter_divider.sv
// iter_divider: sequential radix-2 restoring divider, one quotient bit per clock, start/done handshake
// Ports: clk, rst (sync, active-high); start/A/B/SIGNED request and operands (captured when idle);
// busy high in RUN/FINISH; done one-cycle result pulse; Q/R quotient/remainder and
// div_by_zero flag, all held until the next accepted start.
// Optional feature: define DIV_SIGNED_EN to honour SIGNED (two's-complement division).
module iter_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         SIGNED,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0] r_rem, r_quo, r_div;
  logic [N:0] w_trial;
  logic [N-1:0] w_rem, w_quo, w_a_mag, w_b_mag, w_q_out, w_r_out;
  // Trial subtraction in N+1 bits: the shifted remainder can exceed N bits before the subtract.
  assign w_trial = {r_rem, r_quo[N-1]} - {1'b0, r_div};
  assign w_rem = w_trial[N] ? {r_rem[N-2:0], r_quo[N-1]} : w_trial[N-1:0];
  assign w_quo = {r_quo[N-2:0], ~w_trial[N]};
`ifdef DIV_SIGNED_EN
  logic r_neg_q, r_neg_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_neg_q <= SIGNED & (A[N-1] ^ B[N-1]);
      r_neg_r <= SIGNED & A[N-1];
    end
  end
  // -2^(N-1) has magnitude 2^(N-1) as unsigned, so the overflow case falls out naturally.
  assign w_a_mag = (SIGNED && A[N-1]) ? -A : A;
  assign w_b_mag = (SIGNED && B[N-1]) ? -B : B;
  assign w_q_out = r_neg_q ? -w_quo : w_quo;
  assign w_r_out = r_neg_r ? -w_rem : w_rem;
`else
  logic w_unused;
  assign w_unused = SIGNED;
  assign w_a_mag = A;
  assign w_b_mag = B;
  assign w_q_out = w_quo;
  assign w_r_out = w_rem;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (B == '0) begin
            r_state     <= FINISH;
            done        <= 1'b1;
            Q           <= '1;
            R           <= A;
            div_by_zero <= 1'b1;
          end else begin
            r_state <= RUN;
            r_cnt   <= CW'(N - 1);
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
          end
        end
        RUN: begin
          r_rem <= w_rem;
          r_quo <= w_quo;
          r_cnt <= r_cnt - 1'b1;
          // Results are registered on the last iteration so done and Q/R appear in the FINISH cycle.
          if (r_cnt == '0) begin
            r_state     <= FINISH;
            done        <= 1'b1;
            Q           <= w_q_out;
            R           <= w_r_out;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: table-driven and scoreboard checks for iter_divider
module tb_iter_divider;
  localparam int N = 32;
  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] q, r;
    logic        dz;
  } vec_t;
  typedef struct {
    logic [31:0] q, r;
    logic        dz;
    int          t;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic busy, done, div_by_zero;
  logic [31:0] q_out, r_out;
  int cyc = 0, n_cmp = 0, n_bad = 0, n_done = 0;
  exp_t sb[$];
  vec_t vt[16];
  iter_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in), .SIGNED(sgn),
    .busy(busy), .done(done), .Q(q_out), .R(r_out), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  function automatic vec_t model(logic [31:0] a, logic [31:0] b, logic s);
    vec_t v;
    logic signed [31:0] da, db;
    v.a = a; v.b = b; v.s = s; v.dz = 1'b0;
    da = a; db = b;
    if (b == 0) begin
      v.q = 32'hFFFF_FFFF; v.r = a; v.dz = 1'b1;
`ifdef DIV_SIGNED_EN
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      v.q = 32'h8000_0000; v.r = 0;
    end else if (s) begin
      v.q = da / db; v.r = da % db;
`endif
    end else begin
      v.q = a / b; v.r = a % b;
    end
    return v;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("Q", q_out, e.q);
        chk("R", r_out, e.r);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("done_cycle", cyc, e.t);
        chk("busy_at_done", 32'(busy), 1);
      end
    end
  end
  task automatic issue(input vec_t v);
    start = 1'b1; a_in = v.a; b_in = v.b; sgn = v.s;
    sb.push_back('{v.q, v.r, v.dz, cyc + 1 + (v.dz ? 0 : N)});
    @(posedge clk);
    #1 start = 1'b0; a_in = $urandom; b_in = $urandom; sgn = 1'($urandom);
  endtask
  task automatic wait_done(input int target);
    for (int i = 0; i < N + 5 && n_done < target; i++) @(posedge clk);
    if (n_done < target) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got %0d done pulses expected %0d", n_done, target);
    end
  endtask
  task automatic run_op(input vec_t v);
    int tgt;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    tgt = n_done + 1;
    issue(v);
    wait_done(tgt);
  endtask
  initial begin
    vec_t v;
    int tgt;
    vt[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    vt[1]  = '{32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vt[2]  = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vt[3]  = '{32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0};
    vt[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0};
    vt[5]  = '{32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0};
    vt[6]  = '{32'h8000_0000, 32'd2, 1'b0, 32'h4000_0000, 32'd0, 1'b0};
    vt[7]  = '{32'h1234_5678, 32'h100, 1'b0, 32'h0012_3456, 32'h78, 1'b0};
    vt[8]  = '{32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};
    vt[9]  = '{32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0};
`ifdef DIV_SIGNED_EN
    vt[10] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vt[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
    vt[12] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0};
    vt[13] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0};
    vt[14] = '{32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
`else
    vt[10] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0};
    vt[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0};
    vt[12] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0};
    vt[13] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'hFFFF_FFF9, 1'b0};
    vt[14] = '{32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
`endif
    vt[15] = '{32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd1, 1'b0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_Q", q_out, 0);
    chk("reset_R", r_out, 0);
    chk("reset_dz", 32'(div_by_zero), 0);
    for (int i = 0; i < 16; i++) run_op(vt[i]);
    // start re-pulsed mid-operation must be ignored
    @(negedge clk);
    tgt = n_done + 1;
    issue(vt[0]);
    repeat (9) @(negedge clk);
    chk("busy_mid_run", 32'(busy), 1);
    start = 1'b1; a_in = 32'd5; b_in = 32'd1; sgn = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(tgt);
    repeat (N + 4) @(negedge clk);
    chk("no_second_op", 32'(busy), 0);
    // reset mid-RUN aborts with all outputs cleared and no done
    @(negedge clk);
    issue(model(32'd1000, 32'd3, 1'b0));
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_Q", q_out, 0);
    chk("abort_R", r_out, 0);
    chk("abort_dz", 32'(div_by_zero), 0);
    tgt = n_done + 1;
    issue(model(32'd1000, 32'd3, 1'b0));
    wait_done(tgt);
    // randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (i % 2 ? 32'($urandom_range(1, 300)) : $urandom);
      run_op(model(ra, rb, 1'(i % 3 == 0)));
    end
    repeat (N + 4) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL pending: got %0d outstanding results expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
